shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter and write sequencer that shares one DATA_W-bit storage register among N_REQ requesters. Each requester raises a request with its data. The block grants one requester at a time, loads that requester's data into the shared register, and acknowledges the write. It sits between the lab's requester stimulus/logic blocks and the single storage element they contend for, and replaces ad-hoc latch enables with a clocked, handshaked write path.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of the shared register and of each requester's data
- IDX_W, $clog2(N_REQ), width of the owner index (derived; do not override)

Ports:
- CLK  in  1  system clock; all state changes on its rising edge
- CLR  in  1  synchronous, active-high reset
- REQ  in  N_REQ  per-requester write request; level, held until ACK
- D_IN  in  N_REQ*DATA_W  requester data; slice i = D_IN[i*DATA_W +: DATA_W]
- GNT  out  N_REQ  one-hot grant, registered
- ACK  out  1  one-cycle pulse: the granted write has completed
- Q  out  DATA_W  shared register contents
- OWNER  out  IDX_W  index of the requester that last wrote Q
- VALID  out  1  Q holds written data (0 after reset)

## Operation
- Reset (CLR=1 at an edge) overrides everything. It sets state=IDLE, GNT=0, ACK=0, Q=0, OWNER=0, VALID=0, and last_winner=N_REQ-1, so requester 0 has first priority.
- The FSM has three states: IDLE, GRANT, DONE.
- **IDLE**
  - If REQ is nonzero: pick the first set bit searching upward from last_winner+1, wrapping modulo N_REQ.
  - Set GNT to that one-hot value and go to GRANT.
  - Otherwise stay in IDLE with GNT=0.
- **GRANT**
  - If REQ[granted] is still 1: Q <= D_IN slice of the granted requester, OWNER <= granted index, VALID <= 1, ACK <= 1, go to DONE.
  - If REQ[granted] is 0 (withdrawn): GNT <= 0, no write, no ACK, last_winner unchanged, go to IDLE.
- **DONE**
  - GNT <= 0, ACK <= 0, last_winner <= granted index, go to IDLE.
  - The requester drops REQ on seeing ACK.
  - REQ is ignored in DONE. A REQ still high in the following IDLE counts as a new request.
- Requests from non-granted requesters are never lost. They are served in round-robin order in later IDLE cycles.
- D_IN of non-granted requesters is never sampled.
- GNT is one-hot or zero at all times. It is never asserted in IDLE.
- Q changes only on a completed GRANT→DONE transition or on reset.

## Timing
- REQ is sampled at edge k (IDLE). GNT goes high after edge k.
- Q, OWNER, VALID and ACK update after edge k+1.
- GNT and ACK drop after edge k+2.
- GNT is high for exactly 2 cycles. ACK is high for exactly 1 cycle, coincident with the second GNT cycle.
- Earliest next grant is after edge k+3, so peak throughput is one write per 3 cycles.
- D_IN must be stable at edge k+1. Changes to D_IN outside that edge have no effect.
- Withdrawal: if REQ[granted] is low at edge k+1, GNT drops after k+1 and the FSM is back in IDLE. The next arbitration happens at edge k+2.
- CLR during GRANT or DONE: the in-flight write is discarded, or Q is cleared if it already completed. Outputs reach reset values after that edge. No ACK appears afterwards.
- Simultaneous requests: exactly one winner per arbitration, chosen per the round-robin rule.

## Structure
- Package shared_reg_arbiter_pkg holds:
  - state enum (IDLE, GRANT, DONE) as a 2-bit localparam encoding;
  - default N_REQ/DATA_W constants.
- Sub-module rr_pick (combinational):
  - inputs req[N_REQ-1:0], last[IDX_W-1:0];
  - outputs any, idx[IDX_W-1:0], onehot[N_REQ-1:0].
  - The top module holds only the FSM and registers.

## Test plan
- **Reset:** CLR=1 for 2 cycles with random REQ/D_IN → GNT=0, ACK=0, Q=0x00, OWNER=0, VALID=0.
- **Single write:** REQ=0100, D_IN[2]=0xA5, REQ dropped on ACK.
  - GNT=0100 on cycles k+1..k+2; ACK only on cycle k+2.
  - Q=0xA5, OWNER=2, VALID=1 from k+2.
- **Round-robin:** REQ=1111 held; each requester drops its bit on its ACK; D_IN[i]=0x10+i.
  - Grant order 0,1,2,3; Q sequence 0x10,0x11,0x12,0x13, one write per 3 cycles.
  - Then re-raise REQ=0001|1000 → grant 0 (after 3), then 3.
- **Withdrawal:** REQ=0010, D_IN[1]=0x3C; drop REQ[1] at edge k+1.
  - No ACK; Q unchanged; GNT low after k+1.
  - Next REQ=0011 → requester 0 granted first (last_winner not advanced).
- **Reset mid-operation:** raise REQ=0001 with D_IN[0]=0xFF, assert CLR at edge k+1.
  - Q=0x00, VALID=0, no ACK.
  - After CLR release, the same request completes normally with Q=0xFF.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared types and defaults for the shared register arbiter
package shared_reg_arbiter_pkg;

  localparam int DEFAULT_N_REQ  = 4;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last) + off) % N_REQ);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin write sequencer for one shared storage register
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEFAULT_N_REQ,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*DATA_W-1:0] D_IN,
  output logic [N_REQ-1:0]        GNT,
  output logic                    ACK,
  output logic [DATA_W-1:0]       Q,
  output logic [IDX_W-1:0]        OWNER,
  output logic                    VALID
);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               ack_q, ack_d;
  logic [DATA_W-1:0]  q_q, q_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_onehot;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (REQ),
    .last   (last_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ack_d   = ack_q;
    q_d     = q_q;
    owner_d = owner_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        ack_d = 1'b0;
        if (pick_any) begin
          gnt_d   = pick_onehot;
          gidx_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request abandons the slot without advancing the round-robin pointer.
        if (REQ[gidx_q]) begin
          q_d     = D_IN[int'(gidx_q)*DATA_W +: DATA_W];
          owner_d = gidx_q;
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        ack_d   = 1'b0;
        last_d  = gidx_q;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign GNT   = gnt_q;
  assign ACK   = ack_q;
  assign Q     = q_q;
  assign OWNER = owner_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed vector table plus randomized model check of shared_reg_arbiter
module tb_shared_reg_arbiter;

  logic        CLK;
  logic        CLR;
  logic [3:0]  REQ;
  logic [31:0] D_IN;
  logic [3:0]  GNT;
  logic        ACK;
  logic [7:0]  Q;
  logic [1:0]  OWNER;
  logic        VALID;

  int total = 0;
  int bad   = 0;

  shared_reg_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .REQ   (REQ),
    .D_IN  (D_IN),
    .GNT   (GNT),
    .ACK   (ACK),
    .Q     (Q),
    .OWNER (OWNER),
    .VALID (VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        clr;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic [3:0] r, input logic [31:0] d,
                     input logic [3:0] g, input logic a, input logic [7:0] q,
                     input logic [1:0] o, input logic v);
    vec_t t;
    t.clr = c; t.req = r; t.din = d; t.gnt = g; t.ack = a; t.q = q; t.owner = o; t.valid = v;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then compare the registered outputs.
  task automatic step(input string nm, input int n, input logic c, input logic [3:0] r,
                      input logic [31:0] d, input logic [3:0] eg, input logic ea,
                      input logic [7:0] eq, input logic [1:0] eo, input logic ev);
    CLR  = c;
    REQ  = r;
    D_IN = d;
    @(posedge CLK);
    #1;
    total++;
    if (GNT !== eg || ACK !== ea || Q !== eq || OWNER !== eo || VALID !== ev) begin
      bad++;
      $display("FAIL %s #%0d got gnt=%b ack=%b q=%h owner=%0d valid=%b want gnt=%b ack=%b q=%h owner=%0d valid=%b",
               nm, n, GNT, ACK, Q, OWNER, VALID, eg, ea, eq, eo, ev);
    end
  endtask

  // Transaction-level reference: a write occupies a grant cycle and an ack cycle.
  int         m_phase;
  int         m_sel;
  int         m_last;
  logic [3:0] m_gnt;
  logic       m_ack;
  logic [7:0] m_q;
  logic [1:0] m_owner;
  logic       m_valid;

  function automatic int rr_choose(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++)
      if (r[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic c, input logic [3:0] r, input logic [31:0] d);
    if (c) begin
      m_phase = 0; m_sel = 0; m_last = 3;
      m_gnt = '0; m_ack = 1'b0; m_q = '0; m_owner = '0; m_valid = 1'b0;
    end else if (m_phase == 0) begin
      if (r != 4'b0) begin
        m_sel   = rr_choose(r, m_last);
        m_gnt   = 4'b1 << m_sel;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (r[m_sel]) begin
        m_q     = d[m_sel*8 +: 8];
        m_owner = 2'(m_sel);
        m_valid = 1'b1;
        m_ack   = 1'b1;
        m_phase = 2;
      end else begin
        m_gnt   = '0;
        m_phase = 0;
      end
    end else begin
      m_gnt   = '0;
      m_ack   = 1'b0;
      m_last  = m_sel;
      m_phase = 0;
    end
  endtask

  logic [3:0]  req_v;
  logic [31:0] din_v;
  logic        clr_v;

  initial begin
    CLR = 1'b1; REQ = '0; D_IN = '0;

    // reset with busy inputs
    add(1, 4'b1011, 32'hDEADBEEF, 4'b0000, 0, 8'h00, 0, 0);
    add(1, 4'b0110, 32'h12345678, 4'b0000, 0, 8'h00, 0, 0);
    // single write from requester 2
    add(0, 4'b0100, 32'h00A50000, 4'b0100, 0, 8'h00, 0, 0);
    add(0, 4'b0100, 32'h00A50000, 4'b0100, 1, 8'hA5, 2, 1);
    add(0, 4'b0000, 32'h00A50000, 4'b0000, 0, 8'hA5, 2, 1);
    // reset, then all four requesting
    add(1, 4'b0000, 32'h13121110, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 32'h13121110, 4'b0001, 0, 8'h00, 0, 0);
    add(0, 4'b1111, 32'h13121110, 4'b0001, 1, 8'h10, 0, 1);
    add(0, 4'b1110, 32'h13121110, 4'b0000, 0, 8'h10, 0, 1);
    add(0, 4'b1110, 32'h13121110, 4'b0010, 0, 8'h10, 0, 1);
    add(0, 4'b1110, 32'h13121110, 4'b0010, 1, 8'h11, 1, 1);
    add(0, 4'b1100, 32'h13121110, 4'b0000, 0, 8'h11, 1, 1);
    add(0, 4'b1100, 32'h13121110, 4'b0100, 0, 8'h11, 1, 1);
    add(0, 4'b1100, 32'h13121110, 4'b0100, 1, 8'h12, 2, 1);
    add(0, 4'b1000, 32'h13121110, 4'b0000, 0, 8'h12, 2, 1);
    add(0, 4'b1000, 32'h13121110, 4'b1000, 0, 8'h12, 2, 1);
    add(0, 4'b1000, 32'h13121110, 4'b1000, 1, 8'h13, 3, 1);
    add(0, 4'b0000, 32'h13121110, 4'b0000, 0, 8'h13, 3, 1);
    // wrap: 0 wins after 3, then 3
    add(0, 4'b1001, 32'h13121110, 4'b0001, 0, 8'h13, 3, 1);
    add(0, 4'b1001, 32'h13121110, 4'b0001, 1, 8'h10, 0, 1);
    add(0, 4'b1000, 32'h13121110, 4'b0000, 0, 8'h10, 0, 1);
    add(0, 4'b1000, 32'h13121110, 4'b1000, 0, 8'h10, 0, 1);
    add(0, 4'b1000, 32'h13121110, 4'b1000, 1, 8'h13, 3, 1);
    add(0, 4'b0000, 32'h13121110, 4'b0000, 0, 8'h13, 3, 1);
    // withdrawal of requester 1, pointer must stay put
    add(0, 4'b0010, 32'h00003C00, 4'b0010, 0, 8'h13, 3, 1);
    add(0, 4'b0000, 32'h00003C00, 4'b0000, 0, 8'h13, 3, 1);
    add(0, 4'b0011, 32'h00003C77, 4'b0001, 0, 8'h13, 3, 1);
    add(0, 4'b0011, 32'h00003C77, 4'b0001, 1, 8'h77, 0, 1);
    add(0, 4'b0010, 32'h00003C77, 4'b0000, 0, 8'h77, 0, 1);
    add(0, 4'b0010, 32'h00003C77, 4'b0010, 0, 8'h77, 0, 1);
    add(0, 4'b0010, 32'h00003C77, 4'b0010, 1, 8'h3C, 1, 1);
    add(0, 4'b0000, 32'h00003C77, 4'b0000, 0, 8'h3C, 1, 1);
    // reset in the grant cycle, then the same request completes; data sampled only at the write edge
    add(0, 4'b0001, 32'h000000FF, 4'b0001, 0, 8'h3C, 1, 1);
    add(1, 4'b0001, 32'h000000FF, 4'b0000, 0, 8'h00, 0, 0);
    add(0, 4'b0001, 32'h00000011, 4'b0001, 0, 8'h00, 0, 0);
    add(0, 4'b0001, 32'h000000FF, 4'b0001, 1, 8'hFF, 0, 1);
    add(0, 4'b0000, 32'h00000022, 4'b0000, 0, 8'hFF, 0, 1);

    foreach (vecs[i])
      step("vec", i, vecs[i].clr, vecs[i].req, vecs[i].din,
           vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].owner, vecs[i].valid);

    // reset landing on the ack cycle clears the completed write and no ack follows
    step("clr_done", 0, 0, 4'b0001, 32'h0000005A, 4'b0001, 0, 8'hFF, 0, 1);
    step("clr_done", 1, 0, 4'b0001, 32'h0000005A, 4'b0001, 1, 8'h5A, 0, 1);
    step("clr_done", 2, 1, 4'b0001, 32'h0000005A, 4'b0000, 0, 8'h00, 0, 0);
    step("clr_done", 3, 0, 4'b0000, 32'h0000005A, 4'b0000, 0, 8'h00, 0, 0);
    step("clr_done", 4, 0, 4'b0000, 32'h0000005A, 4'b0000, 0, 8'h00, 0, 0);

    // randomized requesters: hold until ack, occasionally withdraw, occasional reset
    req_v = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_v[i]) begin
          if (m_ack && m_gnt[i]) req_v[i] = 1'b0;
          else if ($urandom_range(0, 31) == 0) req_v[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_v[i] = 1'b1;
        end
      end
      din_v = $urandom;
      clr_v = (n == 0) || ($urandom_range(0, 63) == 0);
      model_step(clr_v, req_v, din_v);
      step("rand", n, clr_v, req_v, din_v, m_gnt, m_ack, m_q, m_owner, m_valid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
